// File: rtl/servant_spi_bus_arbiter.sv
// Arbitrates the SERV instruction and data Wishbone buses onto the single
// port of the SPI flash/RAM master. Keeps a one-word instruction buffer and
// a watchdog that forces completion when the SPI device never acknowledges.
module servant_spi_bus_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 24,
  parameter int unsigned TIMEOUT       = 4096
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-3:0] i_wb_adr,
  input  logic                     i_wb_cyc,
  output logic [31:0]              i_wb_rdt,
  output logic                     i_wb_ack,
  input  logic [ADDRESS_WIDTH-3:0] d_wb_adr,
  input  logic [31:0]              d_wb_dat,
  input  logic [3:0]               d_wb_sel,
  input  logic                     d_wb_we,
  input  logic                     d_wb_cyc,
  output logic [31:0]              d_wb_rdt,
  output logic                     d_wb_ack,
  output logic [ADDRESS_WIDTH-3:0] m_address,
  output logic [31:0]              m_wr_data,
  output logic [3:0]               m_wb_sel,
  output logic                     m_wb_we,
  output logic                     m_wb_cyc,
  input  logic [31:0]              m_rd_data,
  input  logic                     m_wb_ack,
  output logic                     timeout_err
);

  localparam int unsigned AW = ADDRESS_WIDTH - 2;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StIbus, StDbus, StResp, StHit} state_e;

  state_e          state_q, state_d;
  logic            last_d_q;    // 1: dbus won the most recent tie
  logic            gnt_d_q;     // access being answered belongs to dbus
  logic [CW-1:0]   cnt_q;
  logic [31:0]     resp_q;
  logic            buf_valid_q;
  logic [AW-1:0]   buf_tag_q;
  logic [31:0]     buf_data_q;

  logic i_req, d_req, tie, sel_i, hit, expire;

  // A requester whose ack is high this cycle still shows cyc; it is not a new request.
  assign i_req  = i_wb_cyc && !i_wb_ack;
  assign d_req  = d_wb_cyc && !d_wb_ack;
  assign tie    = i_req && d_req;
  assign sel_i  = tie ? last_d_q : i_req;
  assign hit    = sel_i && buf_valid_q && (buf_tag_q == i_wb_adr);
  // A real ack in the final watchdog cycle takes priority over expiry.
  assign expire = !m_wb_ack && (cnt_q == CntLast);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (hit)        state_d = StHit;
        else if (sel_i) state_d = StIbus;
        else if (d_req) state_d = StDbus;
      end
      StIbus, StDbus: begin
        if (m_wb_ack || expire) state_d = StResp;
      end
      StResp, StHit: state_d = StIdle;
      default:       state_d = StIdle;
    endcase
  end

  // Grant latching, downstream handshake, watchdog, buffer and responses.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_d_q    <= 1'b1;
      gnt_d_q     <= 1'b0;
      cnt_q       <= '0;
      resp_q      <= '0;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
      m_address   <= '0;
      m_wr_data   <= '0;
      m_wb_sel    <= '0;
      m_wb_we     <= 1'b0;
      m_wb_cyc    <= 1'b0;
      i_wb_ack    <= 1'b0;
      d_wb_ack    <= 1'b0;
      i_wb_rdt    <= '0;
      d_wb_rdt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      i_wb_ack <= 1'b0;
      d_wb_ack <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (tie) last_d_q <= !sel_i;
          if (hit) begin
            gnt_d_q <= 1'b0;
          end else if (sel_i) begin
            gnt_d_q   <= 1'b0;
            m_address <= i_wb_adr;
            m_wr_data <= '0;
            m_wb_sel  <= 4'hF;
            m_wb_we   <= 1'b0;
            m_wb_cyc  <= 1'b1;
            cnt_q     <= '0;
          end else if (d_req) begin
            gnt_d_q   <= 1'b1;
            m_address <= d_wb_adr;
            m_wr_data <= d_wb_dat;
            m_wb_sel  <= d_wb_sel;
            m_wb_we   <= d_wb_we;
            m_wb_cyc  <= 1'b1;
            cnt_q     <= '0;
            // Writes to the cached word and status/config accesses drop the buffer.
            if ((d_wb_we && (d_wb_adr == buf_tag_q)) || (d_wb_sel == 4'h0)) begin
              buf_valid_q <= 1'b0;
            end
          end
        end
        StIbus, StDbus: begin
          if (m_wb_ack) begin
            m_wb_cyc <= 1'b0;
            resp_q   <= m_wb_we ? 32'h0 : m_rd_data;
            if (state_q == StIbus) begin
              buf_valid_q <= 1'b1;
              buf_tag_q   <= m_address;
              buf_data_q  <= m_rd_data;
            end
          end else if (expire) begin
            m_wb_cyc    <= 1'b0;
            resp_q      <= 32'hFFFF_FFFF;
            timeout_err <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StResp: begin
          if (gnt_d_q) begin
            d_wb_ack <= 1'b1;
            d_wb_rdt <= resp_q;
          end else begin
            i_wb_ack <= 1'b1;
            i_wb_rdt <= resp_q;
          end
        end
        StHit: begin
          i_wb_ack <= 1'b1;
          i_wb_rdt <= buf_data_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/servant_spi_bus_arbiter.md
# servant_spi_bus_arbiter

Upstream neighbour of the SPI flash/RAM master interface. Arbitrates the SERV instruction bus and data bus onto the master's single Wishbone port. Holds a one-entry instruction-word buffer so repeated fetches of the same word skip the slow SPI transaction. Runs a watchdog on every downstream access so a hung SPI device cannot stall the CPU.

## Interface
Parameters:
- ADDRESS_WIDTH, 24: byte-address width. Must equal the master's ADDRESS_WIDTH.
- TIMEOUT, 4096: clock cycles to wait for m_wb_ack before forcing completion. Minimum 2. Counter width is $clog2(TIMEOUT+1).

Ports:
- clock  input  1  single system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset, sampled on posedge clock.
- i_wb_adr  input  ADDRESS_WIDTH-2  instruction word address [ADDRESS_WIDTH-1:2].
- i_wb_cyc  input  1  instruction request.
- i_wb_rdt  output  32  instruction read data.
- i_wb_ack  output  1  instruction acknowledge, one-cycle pulse.
- d_wb_adr  input  ADDRESS_WIDTH-2  data word address.
- d_wb_dat  input  32  write data.
- d_wb_sel  input  4  byte selects. 4'h0 means the master's status/config access.
- d_wb_we  input  1  write enable.
- d_wb_cyc  input  1  data request.
- d_wb_rdt  output  32  data read data.
- d_wb_ack  output  1  data acknowledge, one-cycle pulse.
- m_address  output  ADDRESS_WIDTH-2  to master `address`.
- m_wr_data  output  32  to master `wr_data`.
- m_wb_sel  output  4  to master `wb_sel`. Driven 4'hF for ibus accesses.
- m_wb_we  output  1  to master `wb_we`.
- m_wb_cyc  output  1  to master `wb_cyc`.
- m_rd_data  input  32  from master `rd_data`.
- m_wb_ack  input  1  from master `wb_ack`.
- timeout_err  output  1  sticky flag: a watchdog expiry has occurred.

## Operation
- All m_* outputs are registered copies of the granted request, latched at grant. They are stable for the whole access.
- States:
  - IDLE: no access in progress.
  - IBUS: instruction access outstanding downstream.
  - DBUS: data access outstanding downstream.
  - RESP: acknowledging the requester.
  - HIT: acknowledging an instruction fetch from the buffer.
- IDLE, at most one action per cycle:
  - Buffer hit: i_wb_cyc && buf_valid && buf_tag == i_wb_adr && ibus selected by arbitration. Go to HIT. No downstream access.
  - Otherwise the selected requester goes to IBUS or DBUS. m_wb_cyc rises the next cycle.
- Arbitration applies only when both cyc inputs are high in IDLE. Round-robin: the bus not granted last wins. The `last` register resets to dbus, so ibus wins the first tie.
- IBUS/DBUS:
  - m_wb_cyc is held high until m_wb_ack is sampled high.
  - On ack: m_wb_cyc drops and m_rd_data is captured into the response register. Go to RESP.
  - A write has its response register cleared to 0.
  - An IBUS completion loads buf_tag = address, buf_data = rdata, buf_valid = 1.
- Watchdog:
  - The counter clears at grant and increments each cycle in IBUS/DBUS.
  - When it reaches TIMEOUT without ack: m_wb_cyc drops, the response is 32'hFFFF_FFFF, timeout_err is set, and the state goes to RESP.
  - A timed-out IBUS does not fill the buffer.
- RESP/HIT:
  - The granted ack is high for exactly one cycle and rdt is valid that cycle.
  - Next state is IDLE.
  - Requesters drop cyc the cycle after ack; a cyc still high in IDLE is treated as a new request.
- Buffer invalidation:
  - Any DBUS write with d_wb_adr == buf_tag clears buf_valid at grant. This covers any sel, including partial writes.
  - Any DBUS access with d_wb_sel == 4'h0 clears buf_valid.
- rdt outputs hold the last response between acks. They are 0 after reset.

## Timing
- Reset values: i_wb_ack=0, d_wb_ack=0, m_wb_cyc=0, m_wb_we=0, m_wb_sel=0, m_address=0, m_wr_data=0, i_wb_rdt=0, d_wb_rdt=0, timeout_err=0, buf_valid=0, state IDLE.
- Reset mid-access drops m_wb_cyc on the next edge. No ack is issued to the requester.
- Hit latency: cyc sampled in IDLE (cycle 0), HIT state (cycle 1), i_wb_ack high in cycle 2.
- Miss latency: request in cycle 0, m_wb_cyc high from cycle 1. If m_wb_ack is sampled in cycle N, m_wb_cyc is low in cycle N+1 and the requester ack is high in cycle N+2.
- Timeout: m_wb_cyc is high for exactly TIMEOUT cycles. The requester ack comes 2 cycles after the last high cycle.
- m_wb_ack arriving in the same cycle the counter hits TIMEOUT: ack wins, real data is returned, and timeout_err is unchanged.
- m_wb_ack outside IBUS/DBUS is ignored.

## Test plan
- Miss then hit: ibus fetch 0x000100 with the master model returning 0xDEADBEEF after 40 cycles → one m_wb_cyc access with m_wb_sel=4'hF and i_wb_rdt=0xDEADBEEF. A second fetch of 0x000100 → i_wb_ack 2 cycles after request, no m_wb_cyc.
- Tie arbitration: i_wb_cyc and d_wb_cyc raised together out of reset → ibus served first, dbus second. A repeated tie → dbus first.
- Write invalidation: after caching 0x000100, dbus write sel=4'h3 to the same address with 0x12345678 → m_wr_data=0x12345678. The next ibus fetch of 0x000100 goes downstream.
- Timeout: TIMEOUT=16, master never acks → m_wb_cyc high for 16 cycles, d_wb_rdt=0xFFFFFFFF, timeout_err=1 and sticky. The following ibus access completes normally.
- Ack/timeout collision: m_wb_ack on exactly cycle TIMEOUT → real data returned, timeout_err stays 0.
- Reset mid-access: reset asserted 5 cycles into a DBUS access → m_wb_cyc=0 next cycle, no d_wb_ack, buf_valid=0.
